regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file with write-to-read bypass and a per-register
//  busy scoreboard. Sits between ID (reads, destination allocation) and EX/WB (writebacks).
//  Serves dual-issue/multi-writeback pipelines. rd_busy_o tells ID to stall on RAW hazards
//  whose producer has not yet written back.
// PARAMETERS
//  XLEN     32  data width of each register
//  NREGS    32  number of architectural registers (power of 2, >=2); AW = $clog2(NREGS)
//  NUM_RD   2   number of combinational read ports
//  NUM_WR   1   number of write ports; higher index = younger = higher priority
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            synchronous reset, active-low
//  rd_addr_i     in   NUM_RD*AW    read addresses, port p at [p*AW +: AW]
//  rd_data_o     out  NUM_RD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  rd_busy_o     out  NUM_RD       1 = register has a pending producer; value not yet valid
//  wr_en_i       in   NUM_WR       write enable per write port
//  wr_addr_i     in   NUM_WR*AW    write addresses
//  wr_data_i     in   NUM_WR*XLEN  write data
//  alloc_en_i    in   1            ID issues an instruction with a destination register
//  alloc_addr_i  in   AW           destination being allocated (marked busy)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): ALL NREGS entries <= 0, all busy bits <= 0. While rst==0,
//    rd_data_o = 0 and rd_busy_o = 0 combinationally. Reset mid-write: write is dropped.
//  - Register 0: reads return 0, never busy, writes/allocs to 0 ignored.
//  - Write: at posedge, for each wr_en_i[w] with addr!=0, regs[addr] <= data. Two ports to the
//    same addr in one cycle: highest w wins.
//  - Read (combinational, 0 latency): addr==0 -> 0; else if any enabled write port matches
//    addr -> bypass that port's wr_data_i (highest w wins); else regs[addr].
//  - Scoreboard, next-state per posedge: any enabled write to r clears busy[r];
//    alloc_en_i to r (r!=0) sets busy[r]. Alloc and write to same r in one cycle: busy stays 1
//    (new producer is younger than the retiring one).
//  - rd_busy_o[p] = busy[addr] & ~(any enabled write to addr this cycle); a register being
//    allocated this cycle is NOT reported busy until the next cycle.
//  - A write to a non-busy register is legal (updates data, busy stays 0).
//  - No X propagation: out-of-range indices impossible since NREGS = 2**AW.
// STRUCTURE
//  - Shared package riscv_pkg: XLEN, REG_AW, REG_ZERO (5'd0) constants; regfile code
//    reads them as parameter defaults.
//  - One sub-module: regfile_bypass_mux (one instance per read port): zero check, priority
//    compare against NUM_WR write ports, selects bypass / array data and computes busy.
//  - Top holds storage array, busy vector, write loop and scoreboard update.
// TESTING
//  1 Reset: write r5=0x1234, assert rst=0 one cycle -> read r5 = 0, all busy = 0; also r31 = 0.
//  2 x0: wr r0=0xFFFF_FFFF, alloc r0 -> read r0 = 0, rd_busy_o = 0.
//  3 Bypass: same cycle wr r7=0xA5A5_0001 and read r7 -> rd_data_o = 0xA5A5_0001; next cycle array
//    read still 0xA5A5_0001.
//  4 Dual write (NUM_WR=2): port0 r3=0x11, port1 r3=0x22 -> bypass and stored value = 0x22.
//  5 Scoreboard: alloc r9; next cycle read r9 -> busy=1; cycle of wr r9=0x55 -> busy=0, data
//    0x55; alloc+wr r9 same cycle -> busy=1 following cycle.
//  6 Random: 10k cycles vs reference model, all params NUM_RD in {2,3}, NUM_WR in {1,2}.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared core-wide constants. The register file takes its default data
//   width, register address width and the hard-wired zero register index
//   from here, so every pipeline stage agrees on them.
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam int          REG_AW   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/regfile_bypass_mux.sv
// ---------------------------------------------------------------------------
// regfile_bypass_mux
//   Read-side logic for one register file read port. Returns zero for the
//   zero register and while reset is held. Otherwise it forwards the data
//   of the youngest (highest index) enabled write port that targets the
//   same register, falling back to the stored array value. It also reports
//   whether the register is still waiting for its producer.
//
// Ports
//   rst        in   1             synchronous active-low reset (forces zeros)
//   rd_addr    in   AW            register being read
//   arr_data   in   XLEN          stored value of regs[rd_addr]
//   arr_busy   in   1             scoreboard bit of regs[rd_addr]
//   wr_en      in   NUM_WR        write enables of all write ports
//   wr_addr    in   NUM_WR*AW     write addresses, port w at [w*AW +: AW]
//   wr_data    in   NUM_WR*XLEN   write data, port w at [w*XLEN +: XLEN]
//   rd_data    out  XLEN          value seen by the reader this cycle
//   rd_busy    out  1             1 = producer has not written back yet
// ---------------------------------------------------------------------------
module regfile_bypass_mux
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int AW     = riscv_pkg::REG_AW,
  parameter int NUM_WR = 1
) (
  input  logic                   rst,
  input  logic [AW-1:0]          rd_addr,
  input  logic [XLEN-1:0]        arr_data,
  input  logic                   arr_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]        rd_data,
  output logic                   rd_busy
);

  logic            hit;
  logic [XLEN-1:0] fwd_data;

  // Scan write ports from oldest to youngest so the last match, i.e. the
  // highest-indexed port, is the one forwarded.
  always_comb begin
    hit      = 1'b0;
    fwd_data = arr_data;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
        hit      = 1'b1;
        fwd_data = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // A register being written back this cycle is already valid for the
  // reader, so the write masks the busy bit.
  always_comb begin
    rd_data = fwd_data;
    rd_busy = arr_busy & ~hit;
    if (!rst || (rd_addr == AW'(REG_ZERO))) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule : regfile_bypass_mux

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Multi-port integer register file with write-to-read bypass and a
//   per-register busy scoreboard. ID reads operands and allocates
//   destinations; EX/WB write results back. rd_busy_o lets ID stall on a
//   RAW hazard whose producer has not yet written back.
//
// Ports
//   clk           in   1            clock, rising edge
//   rst           in   1            synchronous reset, active-low
//   rd_addr_i     in   NUM_RD*AW    read addresses, port p at [p*AW +: AW]
//   rd_data_o     out  NUM_RD*XLEN  read data, port p at [p*XLEN +: XLEN]
//   rd_busy_o     out  NUM_RD       1 = pending producer, value not valid yet
//   wr_en_i       in   NUM_WR       write enable per write port
//   wr_addr_i     in   NUM_WR*AW    write addresses
//   wr_data_i     in   NUM_WR*XLEN  write data
//   alloc_en_i    in   1            ID issues an instruction with a destination
//   alloc_addr_i  in   AW           destination being allocated (marked busy)
//
// Higher write port index = younger instruction = higher priority.
// ---------------------------------------------------------------------------
module regfile_mp_sb
  import riscv_pkg::*;
#(
  parameter  int XLEN   = riscv_pkg::XLEN,
  parameter  int NREGS  = 2**riscv_pkg::REG_AW,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   alloc_en_i,
  input  logic [AW-1:0]          alloc_addr_i
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Retiring writes clear their busy bits first; a same-cycle allocation
  // then sets its bit again because the new producer is younger.
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        busy_next[wr_addr_i[w*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en_i && (alloc_addr_i != AW'(REG_ZERO))) begin
      busy_next[alloc_addr_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Storage and scoreboard. Later loop iterations override earlier ones,
  // so the highest-indexed write port wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != AW'(REG_ZERO))) begin
          regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
        end
      end
      busy <= busy_next;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_bypass_mux #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_mux (
      .rst      (rst),
      .rd_addr  (rd_addr_i[p*AW +: AW]),
      .arr_data (regs[rd_addr_i[p*AW +: AW]]),
      .arr_busy (busy[rd_addr_i[p*AW +: AW]]),
      .wr_en    (wr_en_i),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .rd_data  (rd_data_o[p*XLEN +: XLEN]),
      .rd_busy  (rd_busy_o[p])
    );
  end

endmodule : regfile_mp_sb
